// File: rtl/cdc_pkg.sv
// Shared types and defaults for the toggle req/ack clock-domain-crossing blocks.
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_tx_state_t;

  localparam int CDC_DEFAULT_WIDTH       = 4;
  localparam int CDC_DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit; the output is the last
// stage, so a change on d shows up on q after SYNC_STAGES rising edges.
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift d into the chain; stage 0 is the only flop that may go metastable.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchronizer stages with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase toggle req/ack crossing: one word per handshake.
// Define CDC_HANDSHAKE_TX_TIMEOUT_EN to build the sticky ack-timeout flag.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH          = CDC_DEFAULT_WIDTH,
  parameter int SYNC_STAGES    = CDC_DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ack_async,
  output logic             busy,
  output logic             timeout_err
);

  cdc_tx_state_t    state_q, state_d;
  logic             tx_req_q, tx_req_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             in_ready_q, in_ready_d;
  logic             ack_sync;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (tx_ack_async),
    .q    (ack_sync)
  );

  // Next-state: capture and toggle on accept, release once ack parity matches.
  always_comb begin
    state_d    = state_q;
    tx_req_d   = tx_req_q;
    tx_data_d  = tx_data_q;
    in_ready_d = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = WAIT_ACK;
          tx_req_d   = ~tx_req_q;
          tx_data_d  = in_data;
          in_ready_d = 1'b0;
        end else begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_sync == tx_req_q) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          state_d    = WAIT_ACK;
          in_ready_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // Handshake state and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_req_q   <= 1'b0;
      tx_data_q  <= {WIDTH{1'b0}};
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = ~in_ready_q;
  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Counter sits at zero in IDLE, so it starts from zero on every entry to WAIT_ACK.
  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == IDLE) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if ((state_q == WAIT_ACK) && (cnt_d == CNT_MAX)) begin
      timeout_err_d = 1'b1;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Wait counter and sticky flag; only reset clears the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= {CNT_W{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // The flag can never set in this build; the term only keeps the parameter referenced.
  localparam bit TIMEOUT_EN = 1'b0;
  assign timeout_err = TIMEOUT_EN & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-side (transmitting) end of a two-phase toggle req/ack bus crossing into another clock domain; the destination's existing multi-flop synchronizer samples tx_req/tx_data there.
- Accepts one word per handshake from local logic.
- Holds tx_data stable while the transfer is outstanding.
- Toggles tx_req once per word.
- Waits for the destination's toggled ack, which it synchronizes locally, before accepting the next word.

Parameters:
- WIDTH, 4, data word width in bits.
- SYNC_STAGES, 2, flop stages on the ack input; legal range 2..4.
- TIMEOUT_CYCLES, 1024, ack wait limit in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  source-domain clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- in_valid  input  1  local word available.
- in_data  input  WIDTH  local word.
- in_ready  output  1  block can accept a word this cycle.
- tx_req  output  1  toggle request to the destination domain; driven directly from a flop.
- tx_data  output  WIDTH  held word to the destination domain; driven directly from flops.
- tx_ack_async  input  1  toggle ack from the destination domain, asynchronous to clk.
- busy  output  1  transfer outstanding, equal to !in_ready.
- timeout_err  output  1  sticky ack-timeout flag; constant 0 without the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state=IDLE, tx_req=0, tx_data=0, all ack sync flops=0, in_ready=1, busy=0, timeout_err=0.
- States: IDLE, WAIT_ACK.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at edge t: tx_data<=in_data, tx_req<=~tx_req, state<=WAIT_ACK.
  - Both outputs change at t+1 together; no glitching.
- WAIT_ACK:
  - in_ready=0. in_valid and in_data are ignored; no queueing.
  - tx_data and tx_req are held constant for the whole state.
- Ack detection:
  - ack_sync is tx_ack_async after SYNC_STAGES flops.
  - Completion condition: ack_sync == tx_req. Then state<=IDLE on the next edge.
  - An ack toggle at the input becomes visible after SYNC_STAGES edges; in_ready rises one cycle later.
- Minimum word period: 1 (accept) + destination round trip + SYNC_STAGES + 1 cycles.
- Simultaneous events:
  - Completion and in_valid in the same cycle: in_valid is not accepted because in_ready=0. The word is taken on the next IDLE cycle.
  - No combinational path from in_valid to in_ready.
- Spurious ack: an ack_sync change while IDLE (ack_sync already equals tx_req) causes no state change.
- Reset mid-transfer: abandons the word and returns all flops to reset values. The destination's reset must be asserted in the same reset event so toggle parity realigns.
- tx_req toggle parity wraps naturally; no counter width limit.

Optional Feature:
- Macro: CDC_HANDSHAKE_TX_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYCLES, timeout_err<=1. It is sticky until reset.
  - The state stays WAIT_ACK, so a late ack still completes normally.
  - The counter saturates.
- Undefined: no counter is built; timeout_err is tied to 0.

Decomposition:
- Package cdc_pkg:
  - typedef enum logic {IDLE, WAIT_ACK} cdc_tx_state_t.
  - Constants CDC_DEFAULT_WIDTH=4 and CDC_DEFAULT_SYNC_STAGES=2.
- One sub-module, cdc_sync_bit:
  - Parameters SYNC_STAGES; ports clk, reset, d, q.
  - Async-reset flop chain, reset value 0.
  - Instantiated for tx_ack_async and reusable by other blocks.

Test Plan:
- Reset release: reset held 3 cycles, then low -> in_ready=1, tx_req=0, tx_data=0, busy=0.
- Single word, SYNC_STAGES=2: in_valid=1, in_data=4'hA at cycle 5 -> cycle 6 tx_req=1, tx_data=4'hA, in_ready=0. Toggle tx_ack_async to 1 at cycle 10 -> in_ready=1 at cycle 13.
- Back-to-back words: in_valid held high with 4'h3 then 4'h5, ack looped back through a 3-cycle model -> tx_req toggles 1 then 0. tx_data is stable between toggles, and each word is accepted exactly once.
- Stall hold: in_data changes to 4'hF every cycle during WAIT_ACK -> tx_data keeps the first captured value 4'h1 until completion.
- Reset mid-transfer: reset asserted 2 cycles after accept, with a random async ack glitch during reset -> all outputs return to reset values. The next word toggles tx_req to 1.
- Timeout, macro defined with TIMEOUT_CYCLES=8: no ack -> timeout_err=1 at the 8th WAIT_ACK cycle. A later ack returns in_ready=1 while timeout_err stays 1. Macro undefined -> timeout_err stays 0.
